// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit.
//   op_e      : opcode encoding carried on the 2-bit op input
//   ST_*      : FSM state encodings used by arith_seq_unit
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/arith_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   start     : load new operands; the first iteration is done in the load cycle
//   a_mag     : dividend magnitude
//   b_mag     : divisor magnitude (non-zero)
//   done      : quotient/remainder valid (iteration count reached WIDTH)
//   quo_mag   : quotient magnitude
//   rem_mag   : remainder magnitude
module arith_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             done,
    output logic [WIDTH-1:0] quo_mag,
    output logic [WIDTH-1:0] rem_mag
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, div_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] src_rem, src_quo, src_div;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic             busy;

    // On start the step operates directly on the incoming operands so that the
    // full quotient is ready WIDTH-1 edges after the load edge.
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_quo  = start ? a_mag : quo_q;
        src_div  = start ? b_mag : div_q;
        trial    = {src_rem, src_quo[WIDTH-1]};
        fits     = trial >= {1'b0, src_div};
        // Partial remainder stays below the divisor, so WIDTH bits suffice.
        rem_step = fits ? WIDTH'(trial - {1'b0, src_div}) : trial[WIDTH-1:0];
        quo_step = {src_quo[WIDTH-2:0], fits};
    end

    assign busy    = (cnt_q != '0) && (cnt_q != CW'(WIDTH));
    assign done    = (cnt_q == CW'(WIDTH));
    assign quo_mag = quo_q;
    assign rem_mag = rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            div_q <= b_mag;
            cnt_q <= CW'(1);
        end else if (busy) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/arith_seq_unit.sv
// Handshaked signed arithmetic unit: add, sub, full-width mul and iterative
// signed divide (quotient low half, remainder high half, truncating to zero).
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready only in IDLE, rst low)
//   a, b, op            : signed operands and opcode (arith_pkg::op_e)
//   out_valid, out_ready: result handshake
//   result              : 2*WIDTH registered result, held until taken
//   err                 : divide-by-zero flag, qualified by out_valid
module arith_seq_unit
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               err
);

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               err_q, err_d;
    logic               quo_neg_q, rem_neg_q;

    logic               accept, b_zero, div_start, div_done;
    logic [2*WIDTH-1:0] a_ext, b_ext, sum, diff, prod;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_mag, rem_mag, quo_fix, rem_fix;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign err       = err_q;

    assign accept    = in_valid && in_ready;
    assign b_zero    = (b == '0);
    assign div_start = accept && (op_e'(op) == OP_DIV) && !b_zero;

    // Sign-extend first: the low 2*WIDTH bits of the unsigned product of the
    // extended operands equal the exact signed product.
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign sum   = a_ext + b_ext;
    assign diff  = a_ext - b_ext;
    assign prod  = a_ext * b_ext;

    // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    arith_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .done    (div_done),
        .quo_mag (quo_mag),
        .rem_mag (rem_mag)
    );

    // Quotient wraps naturally for -2^(WIDTH-1) / -1.
    assign quo_fix = quo_neg_q ? -quo_mag : quo_mag;
    assign rem_fix = rem_neg_q ? -rem_mag : rem_mag;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                    case (op_e'(op))
                        OP_ADD: result_d = sum;
                        OP_SUB: result_d = diff;
                        OP_MUL: result_d = prod;
                        OP_DIV: begin
                            if (b_zero) begin
                                result_d = {a, {WIDTH{1'b1}}};
                                err_d    = 1'b1;
                            end else begin
                                state_d = ST_DIV;
                            end
                        end
                        default: result_d = sum;
                    endcase
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    result_d = {rem_fix, quo_fix};
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            err_q     <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            err_q    <= err_d;
            if (div_start) begin
                quo_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                rem_neg_q <= a[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_arith_seq_unit.sv
// Directed self-checking bench for arith_seq_unit (WIDTH = 16). Expected
// results come from a behavioural model and are queued when a transaction is
// driven, then popped when the unit presents its output.
module tb_arith_seq_unit;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a, b;
    logic [1:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           err;

    int errors = 0;
    int checks = 0;

    logic [2*W:0] sb[$];  // {err, result}

    arith_seq_unit #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        int          sx, sy, q, r;
        logic [31:0] s;
        sx = int'($signed(x));
        sy = int'($signed(y));
        case (o)
            2'b00: begin s = sx + sy; return {1'b0, s}; end
            2'b01: begin s = sx - sy; return {1'b0, s}; end
            2'b10: begin s = sx * sy; return {1'b0, s}; end
            default: begin
                if (y == '0) return {1'b1, x, 16'hFFFF};
                q = sx / sy;
                r = sx % sy;
                return {1'b0, r[W-1:0], q[W-1:0]};
            end
        endcase
    endfunction

    task automatic run_txn(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input int exp_lat, input int hold);
        int           lat;
        logic [2*W:0] exp;
        sb.push_back(model(o, x, y));
        @(negedge clk);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        op        = o;
        out_ready = 1'b0;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        exp = sb.pop_front();
        chk({tag, "_result"}, 64'(result), 64'(exp[2*W-1:0]));
        chk({tag, "_err"}, 64'(err), 64'(exp[2*W]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_result"}, 64'(result), 64'(exp[2*W-1:0]));
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 2'b00;
        out_ready = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_result", 64'(result), 64'd0);
        chk("idle_err", 64'(err), 64'd0);

        run_txn("add_max", 2'b00, 16'h7FFF, 16'h0001, 1, 0);
        run_txn("sub_min", 2'b01, 16'h8000, 16'h0001, 1, 0);
        run_txn("mul_neg", 2'b10, 16'hFFFD, 16'h7FFF, 1, 5);
        run_txn("div_neg", 2'b11, 16'hFFF9, 16'h0002, W + 1, 0);
        run_txn("div_wrap", 2'b11, 16'h8000, 16'hFFFF, W + 1, 0);
        run_txn("div_pos", 2'b11, 16'd1000, 16'hFFF9, W + 1, 2);
        run_txn("div_zero", 2'b11, 16'd1234, 16'h0000, 1, 0);
        run_txn("mul_min", 2'b10, 16'h8000, 16'h8000, 1, 0);

        // Reset in the middle of a divide: result must be discarded
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'd500;
        b        = 16'd7;
        op       = 2'b11;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_idle", 64'(in_ready), 64'd1);
        out_ready = 1'b1;  // must be harmless while nothing is valid
        begin
            int seen = 0;
            for (int i = 0; i < 2 * W; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("midrst_no_stale", 64'(seen), 64'd0);
        end
        out_ready = 1'b0;

        run_txn("add_small", 2'b00, 16'd2, 16'd3, 1, 0);
        chk("add_small_const", 64'(result), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arith_seq_unit.md
# arith_seq_unit

Parametrised, handshaked signed arithmetic unit. It accepts one operand pair plus an opcode per transaction and computes add, sub, mul or iterative signed divide. The result is held until the consumer takes it. It sits between the AXI-Lite register front end and the result registers, with valid/ready on both sides so that multi-cycle divide can stall the producer.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 4. The result is 2*WIDTH bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  unit can accept; high only in IDLE with rst low.
- a  in  WIDTH  signed operand A (dividend for div).
- b  in  WIDTH  signed operand B (divisor for div).
- op  in  2  00 add, 01 sub, 10 mul, 11 div.
- out_valid  out  1  result and err valid.
- out_ready  in  1  consumer accepts the result.
- result  out  2*WIDTH  registered result.
- err  out  1  divide-by-zero indicator; qualified by out_valid.

## Operation
- FSM states: IDLE, DIV, DONE.
  - IDLE → DONE on accept (in_valid & in_ready) when op ≠ div, or when op = div with b = 0.
  - IDLE → DIV on accept when op = div with b ≠ 0.
  - DIV → DONE when the divider iteration count reaches WIDTH.
  - DONE → IDLE when out_ready is high.
- Operands and opcode are captured only on accept. Inputs are ignored outside IDLE.
- add/sub: a ± b computed at WIDTH+1 bits, then sign-extended to 2*WIDTH. There is no overflow in the result.
- mul: full signed product at 2*WIDTH bits, exact.
- div: signed divide, truncating toward zero.
  - result[WIDTH-1:0] = quotient; result[2*WIDTH-1:WIDTH] = remainder.
  - The remainder takes the sign of the dividend.
  - Implemented as magnitude restoring division, one bit per cycle, followed by sign fix-up.
  - a = −2^(WIDTH−1), b = −1: quotient wraps to −2^(WIDTH−1), remainder 0, err 0.
- Divide by zero: quotient = all ones, remainder = a, err = 1. No DIV cycles are spent.
- err = 0 for every result other than divide-by-zero.
- result and err hold stable throughout DONE until the handshake completes.
- Reset mid-operation (DIV or DONE): go to IDLE and discard the in-flight result. No output handshake occurs for it.

## Timing
- Reset values:
  - out_valid = 0, result = 0, err = 0, state = IDLE.
  - in_ready = 0 while rst is high, and 1 in the cycle after rst deasserts.
- Accept at edge t for add/sub/mul/div-by-zero: out_valid high from cycle t+1.
- Accept at edge t for div with b ≠ 0: out_valid high from cycle t+WIDTH+1.
- Output handshake completes on the edge where out_valid & out_ready are both high.
  - in_ready rises the following cycle.
  - Best-case throughput is one transaction per 2 cycles.
- in_ready is combinational from state and rst, with no dependence on in_valid. out_valid is registered.
- out_ready held high while out_valid is low has no effect.
- There is no combinational path from in_valid to out_valid, or from out_ready to in_ready.

## Structure
- Package arith_pkg:
  - op encodings as a 2-bit enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - FSM state enum.
- Sub-module arith_divider, parametrised by WIDTH:
  - Inputs: start, |a|, |b|.
  - Outputs: done, quotient magnitude, remainder magnitude.
  - Contains the iteration counter and the shift/subtract datapath.
- The top level handles sign fix-up, the add/sub/mul datapath, the FSM and the handshake.

## Test plan
- Reset then idle: in_ready = 0 during rst; after release in_ready = 1, out_valid = 0, result = 0.
- add a = 0x7FFF, b = 0x0001 (WIDTH = 16) → result 0x0000_8000 at t+1, err 0. Then sub a = 0x8000, b = 0x0001 → result 0xFFFF_7FFF.
- mul a = −3, b = 0x7FFF → result 0xFFFE_8003 (−98301) at t+1. Hold out_ready low for 5 cycles → result stable, in_ready low throughout.
- div a = −7, b = 2 → quotient 0xFFFD (−3), remainder 0xFFFF (−1), out_valid first at t+17. div a = 0x8000, b = 0xFFFF → quotient 0x8000, remainder 0, err 0.
- div a = 1234, b = 0 → out_valid at t+1, quotient 0xFFFF, remainder 0x04D2, err 1.
- rst asserted at cycle 5 of a divide → next cycle state IDLE, out_valid 0. No stale result appears. A following add 2 + 3 returns 5.
